program_sequencer: RTL

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

---
 rtl/program_sequencer.sv | 86 ++++++++
 1 files changed

// File: rtl/program_sequencer.sv
// Program sequencer: fetches opcodes from a synchronous program ROM and issues
// each one to the control unit for ISSUE_CYCLES cycles, with hold, skip and halt.
module program_sequencer #(
   parameter logic [3:0] NOP_CODE     = 4'b1111,
   parameter int         ISSUE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rstN,
   input  logic        start,
   input  logic [7:0]  startAddr,
   input  logic        hold,
   output logic [7:0]  pcAddr,
   input  logic [7:0]  romData,
   output logic [3:0]  opCode,
   output logic        busy,
   output logic        halted,
   output logic [15:0] instrCount
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] FETCH  = 3'd1;
   localparam logic [2:0] DECODE = 3'd2;
   localparam logic [2:0] EXEC   = 3'd3;
   localparam logic [2:0] HALT   = 3'd4;

   localparam logic [3:0] LAST_CNT = 4'(ISSUE_CYCLES - 1);

   logic [2:0] state;
   logic [3:0] instrReg;
   logic [3:0] execCnt;
   logic [3:0] romOp;
   logic       unusedBits;

   assign romOp      = romData[7:4];
   assign unusedBits = ^romData[3:0];

   always_ff @(posedge clk) begin
      if (!rstN) begin
         state      <= IDLE;
         pcAddr     <= 8'h00;
         instrReg   <= NOP_CODE;
         execCnt    <= 4'd0;
         instrCount <= 16'h0000;
      end else if (!hold) begin
         case (state)
            IDLE, HALT: begin
               if (start) begin
                  pcAddr     <= startAddr;
                  instrCount <= 16'h0000;
                  state      <= FETCH;
               end
            end
            FETCH: state <= DECODE;
            DECODE: begin
               instrReg <= romOp;
               if (romOp == 4'b1111) begin
                  state <= HALT;
               end else if (romOp >= 4'b1011) begin
                  // Reserved opcodes are skipped without being issued or counted
                  pcAddr <= pcAddr + 8'd1;
                  state  <= FETCH;
               end else begin
                  execCnt <= 4'd0;
                  state   <= EXEC;
                  if (instrCount != 16'hFFFF)
                     instrCount <= instrCount + 16'd1;
               end
            end
            EXEC: begin
               execCnt <= execCnt + 4'd1;
               if (execCnt == LAST_CNT) begin
                  pcAddr <= pcAddr + 8'd1;
                  state  <= FETCH;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Hold masks the issued opcode immediately, without waiting for a clock edge
   assign opCode = (state == EXEC && !hold) ? instrReg : NOP_CODE;
   assign busy   = (state == FETCH) || (state == DECODE) || (state == EXEC);
   assign halted = (state == HALT);

endmodule
